// File: rtl/s_inv_serial_pkg.sv
// Shared fixed-point definitions for the serial Kalman stages.
// FXP_N    : total signed word width
// FXP_FRAC : fractional bits (1.0 = 2**FXP_FRAC)
// FXP_MAX / FXP_MIN : saturation bounds of an FXP_N-bit signed word
package s_inv_serial_pkg;

    localparam int FXP_N    = 16;
    localparam int FXP_FRAC = 8;

    localparam logic signed [FXP_N-1:0] FXP_MAX = {1'b0, {(FXP_N-1){1'b1}}};
    localparam logic signed [FXP_N-1:0] FXP_MIN = {1'b1, {(FXP_N-1){1'b0}}};

endpackage

// File: rtl/s_inv_serial_if.sv
// Request/result bundle of the S-inverse stage.
// master : upstream/consumer side (drives start, P*, R*; reads results)
// slave  : the s_inv_serial block
// start             : one-cycle request, sampled only when idle
// P11..P22, R11..R22: N-bit signed fixed-point inputs
// busy, done        : status; done is a one-cycle pulse
// singular          : det(S) was zero for the last run
// Si11..Si22        : N-bit signed fixed-point S^-1
interface s_inv_serial_if
    import s_inv_serial_pkg::*;
#(
    parameter int N = FXP_N
);
    logic                start;
    logic signed [N-1:0] P11, P12, P21, P22;
    logic signed [N-1:0] R11, R12, R21, R22;
    logic                busy;
    logic                done;
    logic                singular;
    logic signed [N-1:0] Si11, Si12, Si21, Si22;

    modport master (
        output start, P11, P12, P21, P22, R11, R12, R21, R22,
        input  busy, done, singular, Si11, Si12, Si21, Si22
    );

    modport slave (
        input  start, P11, P12, P21, P22, R11, R12, R21, R22,
        output busy, done, singular, Si11, Si12, Si21, Si22
    );
endinterface

// File: rtl/fxp_udiv_serial.sv
// Bit-serial unsigned restoring divider, one quotient bit per step.
// clk, rst_n : clock, asynchronous active-low reset
// load       : capture dividend/divisor, clear remainder and step counter
// step       : perform one restoring iteration
// dividend   : QW-bit unsigned dividend
// divisor    : DW-bit unsigned divisor (must be non-zero for a meaningful result)
// quotient   : QW-bit quotient, final after QW steps
// last       : high during the step that completes the QW-th iteration
module fxp_udiv_serial #(
    parameter int QW = 32,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          step,
    input  logic [QW-1:0] dividend,
    input  logic [DW-1:0] divisor,
    output logic [QW-1:0] quotient,
    output logic          last
);
    localparam int CW = $clog2(QW) + 1;

    logic [QW-1:0] q_reg;
    logic [DW-1:0] rem_reg;
    logic [DW-1:0] d_reg;
    logic [CW-1:0] cnt_reg;

    // Remainder stays below the divisor, so the shifted remainder needs
    // only one extra bit and the restored value fits back into DW bits.
    logic [DW:0]   rem_sh;
    logic          ge;
    logic [DW-1:0] rem_next;

    always_comb begin
        rem_sh   = {rem_reg, q_reg[QW-1]};
        ge       = (rem_sh >= {1'b0, d_reg});
        rem_next = ge ? DW'(rem_sh - {1'b0, d_reg}) : rem_sh[DW-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_reg   <= '0;
            rem_reg <= '0;
            d_reg   <= '0;
            cnt_reg <= '0;
        end else if (load) begin
            q_reg   <= dividend;
            rem_reg <= '0;
            d_reg   <= divisor;
            cnt_reg <= '0;
        end else if (step) begin
            q_reg   <= {q_reg[QW-2:0], ge};
            rem_reg <= rem_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign quotient = q_reg;
    assign last     = step && (cnt_reg == CW'(QW-1));
endmodule

// File: rtl/s_inv_serial.sv
// S-inverse stage: S = sat(P + R), then S^-1 of the 2x2 matrix using one
// shared multiplier (plus a second one only for the cross product in DET)
// and a bit-serial restoring divider for 1/det.
// clk   : clock, rising edge
// rst_n : asynchronous active-low reset
// bus   : s_inv_serial_if.slave (start, P*, R*, busy, done, singular, Si*)
module s_inv_serial
    import s_inv_serial_pkg::*;
#(
    parameter int N    = FXP_N,
    parameter int FRAC = FXP_FRAC
) (
    input  logic               clk,
    input  logic               rst_n,
    s_inv_serial_if.slave      bus
);
    localparam int W = 2*N + 2;

    localparam logic signed [N-1:0] MAXN = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] MINN = {1'b1, {(N-1){1'b0}}};
    localparam logic signed [W-1:0] SMAX = {{(N+3){1'b0}}, {(N-1){1'b1}}};
    localparam logic signed [W-1:0] SMIN = {{(N+3){1'b1}}, {(N-1){1'b0}}};
    localparam logic [2*N-1:0]      DIVIDEND = (2*N)'(1) << (2*FRAC);

    typedef enum logic [1:0] {ST_IDLE, ST_DET, ST_DIV, ST_SCALE} state_t;

    function automatic logic signed [N-1:0] sat_n(input logic signed [W-1:0] x);
        if (x > SMAX)      return MAXN;
        else if (x < SMIN) return MINN;
        else               return x[N-1:0];
    endfunction

    state_t              state_reg;
    logic signed [N-1:0] s11_reg, s12_reg, s21_reg, s22_reg;
    logic signed [N-1:0] det_reg;
    logic [1:0]          k_reg;
    logic                busy_reg, done_reg, sing_reg;
    logic signed [N-1:0] si11_reg, si12_reg, si21_reg, si22_reg;

    // Combinational datapath
    logic signed [W-1:0] sum11, sum12, sum21, sum22;
    logic signed [N:0]   num, mul_a, mul_b;
    logic signed [W-1:0] mul_p, cross_p, det_wide;
    logic signed [N-1:0] det_c;
    logic [N-1:0]        det_abs;
    logic [2*N-1:0]      quot;
    logic                div_last;
    logic [N-1:0]        inv_c;
    logic signed [N-1:0] r_c, r_neg, res_c;

    always_comb begin
        sum11 = W'(bus.P11) + W'(bus.R11);
        sum12 = W'(bus.P12) + W'(bus.R12);
        sum21 = W'(bus.P21) + W'(bus.R21);
        sum22 = W'(bus.P22) + W'(bus.R22);

        // Numerators of the adjugate, widened so -(-2^(N-1)) stays exact.
        unique case (k_reg)
            2'd0:    num = $signed({s22_reg[N-1], s22_reg});
            2'd1:    num = -$signed({s12_reg[N-1], s12_reg});
            2'd2:    num = -$signed({s21_reg[N-1], s21_reg});
            default: num = $signed({s11_reg[N-1], s11_reg});
        endcase

        // The quotient of 2^(2*FRAC)/|det| is clamped to the positive range.
        inv_c = (|quot[2*N-1:N-1]) ? {1'b0, {(N-1){1'b1}}} : quot[N-1:0];

        // Shared multiplier: S11*S22 while in DET, num*inv while scaling.
        if (state_reg == ST_DET) begin
            mul_a = $signed({s11_reg[N-1], s11_reg});
            mul_b = $signed({s22_reg[N-1], s22_reg});
        end else begin
            mul_a = num;
            mul_b = $signed({1'b0, inv_c});
        end
        mul_p   = W'(mul_a) * W'(mul_b);
        cross_p = W'(s12_reg) * W'(s21_reg);

        det_wide = mul_p - cross_p;
        det_c    = sat_n(det_wide >>> FRAC);
        det_abs  = det_c[N-1] ? unsigned'(-det_c) : unsigned'(det_c);

        r_c   = sat_n(mul_p >>> FRAC);
        r_neg = sat_n(-W'(r_c));
        res_c = det_reg[N-1] ? r_neg : r_c;
    end

    fxp_udiv_serial #(
        .QW (2*N),
        .DW (N)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_reg == ST_DET),
        .step     (state_reg == ST_DIV),
        .dividend (DIVIDEND),
        .divisor  (det_abs),
        .quotient (quot),
        .last     (div_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            s11_reg   <= '0;
            s12_reg   <= '0;
            s21_reg   <= '0;
            s22_reg   <= '0;
            det_reg   <= '0;
            k_reg     <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sing_reg  <= 1'b0;
            si11_reg  <= '0;
            si12_reg  <= '0;
            si21_reg  <= '0;
            si22_reg  <= '0;
        end else begin
            done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        s11_reg   <= sat_n(sum11);
                        s12_reg   <= sat_n(sum12);
                        s21_reg   <= sat_n(sum21);
                        s22_reg   <= sat_n(sum22);
                        sing_reg  <= 1'b0;
                        busy_reg  <= 1'b1;
                        state_reg <= ST_DET;
                    end
                end
                ST_DET: begin
                    det_reg <= det_c;
                    if (det_c == '0) begin
                        sing_reg  <= 1'b1;
                        si11_reg  <= '0;
                        si12_reg  <= '0;
                        si21_reg  <= '0;
                        si22_reg  <= '0;
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end else begin
                        state_reg <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if (div_last) begin
                        k_reg     <= '0;
                        state_reg <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    unique case (k_reg)
                        2'd0:    si11_reg <= res_c;
                        2'd1:    si12_reg <= res_c;
                        2'd2:    si21_reg <= res_c;
                        default: si22_reg <= res_c;
                    endcase
                    k_reg <= k_reg + 2'd1;
                    if (k_reg == 2'd3) begin
                        done_reg  <= 1'b1;
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.singular = sing_reg;
    assign bus.Si11     = si11_reg;
    assign bus.Si12     = si12_reg;
    assign bus.Si21     = si21_reg;
    assign bus.Si22     = si22_reg;
endmodule

// File: tb/tb_s_inv_serial.sv
// Self-checking bench for s_inv_serial: directed corner cases plus random
// P/R vectors checked against an integer reference of the S^-1 rules.
module tb_s_inv_serial;
    localparam int N    = 16;
    localparam int FRAC = 8;
    localparam int LAT  = 2*N + 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    s_inv_serial_if #(.N(N)) bus();

    s_inv_serial #(.N(N), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint sat16(input longint x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    // Reference: index order 0=11, 1=12, 2=21, 3=22.
    task automatic model(input longint p[4], input longint r[4],
                         output longint si[4], output bit sing);
        longint s[4];
        longint det, q, inv, nm[4];
        for (int i = 0; i < 4; i++) s[i] = sat16(p[i] + r[i]);
        det = sat16((s[0]*s[3] - s[1]*s[2]) >>> FRAC);
        sing = (det == 0);
        for (int i = 0; i < 4; i++) si[i] = 0;
        if (!sing) begin
            q   = (longint'(1) << (2*FRAC)) / (det < 0 ? -det : det);
            inv = (q > 32767) ? 32767 : q;
            nm[0] = s[3]; nm[1] = -s[1]; nm[2] = -s[2]; nm[3] = s[0];
            for (int i = 0; i < 4; i++) begin
                si[i] = sat16((nm[i]*inv) >>> FRAC);
                if (det < 0) si[i] = sat16(-si[i]);
            end
        end
    endtask

    task automatic drive_pr(input longint p[4], input longint r[4]);
        bus.P11 = N'(p[0]); bus.P12 = N'(p[1]); bus.P21 = N'(p[2]); bus.P22 = N'(p[3]);
        bus.R11 = N'(r[0]); bus.R12 = N'(r[1]); bus.R21 = N'(r[2]); bus.R22 = N'(r[3]);
    endtask

    function automatic longint rnd(input int mode);
        case (mode)
            0:       return longint'($urandom_range(0, 65535)) - 32768;
            1:       return longint'($urandom_range(0, 1024)) - 512;
            default: return longint'($urandom_range(0, 64)) - 32;
        endcase
    endfunction

    // Starts a run in the current cycle (called #1 after an edge), counts
    // edges after the accepting edge until done is seen, then checks.
    // poke: re-pulse start while busy; scramble: change P/R after acceptance.
    task automatic run_case(input string tag, input longint p[4], input longint r[4],
                            input bit scramble, input bit poke);
        longint si[4];
        bit     sing;
        int     lat;
        longint junk[4];
        model(p, r, si, sing);
        drive_pr(p, r);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        if (scramble) begin
            for (int i = 0; i < 4; i++) junk[i] = rnd(0);
            drive_pr(junk, junk);
        end
        lat = 0;
        while (lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (poke && lat == 10) bus.start = 1'b1;
            if (poke && lat == 11) bus.start = 1'b0;
            if (bus.done) break;
        end
        bus.start = 1'b0;
        // Singular: done in the cycle after the DET edge, i.e. one edge after acceptance.
        check_val({tag, "_lat"}, lat, sing ? 1 : LAT);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_sing"}, bus.singular, sing);
        check_val({tag, "_si11"}, bus.Si11, si[0]);
        check_val({tag, "_si12"}, bus.Si12, si[1]);
        check_val({tag, "_si21"}, bus.Si21, si[2]);
        check_val({tag, "_si22"}, bus.Si22, si[3]);
        $display("[TB] %s lat=%0d sing=%0d Si=%0d,%0d,%0d,%0d", tag, lat, sing,
                 si[0], si[1], si[2], si[3]);
    endtask

    initial begin
        longint p[4], r[4], z[4], idp[4];
        z   = '{0, 0, 0, 0};
        idp = '{256, 0, 0, 256};
        bus.start = 1'b0;
        drive_pr(z, z);

        #2;
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_sing", bus.singular, 0);
        check_val("rst_si11", bus.Si11, 0);
        check_val("rst_si22", bus.Si22, 0);
        #20 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_case("identity", idp, idp, 1'b1, 1'b0);
        check_val("identity_si11_abs", bus.Si11, 128);
        run_case("singular", z, z, 1'b0, 1'b0);
        check_val("singular_flag", bus.singular, 1);
        p = '{0, 256, 256, 0};
        run_case("negdet", p, z, 1'b0, 1'b0);
        check_val("negdet_si12_abs", bus.Si12, 256);
        p = '{16, 0, 0, 16};
        run_case("satinv", p, z, 1'b0, 1'b0);
        check_val("satinv_si11_abs", bus.Si11, 2047);
        p = '{32767, 0, 0, 256};
        r = '{32767, 0, 0, 0};
        run_case("sats11", p, r, 1'b0, 1'b0);
        check_val("sats11_si22_abs", bus.Si22, 255);

        // Start while busy is ignored; P/R also scrambled after acceptance.
        p = '{300, -40, 25, 500};
        r = '{12, 3, -7, 90};
        run_case("poke", p, r, 1'b1, 1'b1);

        // Back-to-back: the next start is issued in the done cycle.
        check_val("b2b_in_done", bus.done, 1);
        run_case("b2b", idp, z, 1'b0, 1'b0);

        // Reset in the middle of DIV
        run_case("pre_rst", idp, idp, 1'b0, 1'b0);
        drive_pr(idp, z);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        check_val("mid_busy", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check_val("arst_busy", bus.busy, 0);
        check_val("arst_done", bus.done, 0);
        check_val("arst_si11", bus.Si11, 0);
        check_val("arst_si22", bus.Si22, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_case("post_rst", idp, idp, 1'b0, 1'b0);

        // Random
        for (int t = 0; t < 500; t++) begin
            int mode;
            mode = $urandom_range(0, 3);
            for (int i = 0; i < 4; i++) begin
                p[i] = (mode == 3) ? 0 : rnd(mode);
                r[i] = (mode == 3) ? 0 : rnd(mode);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            run_case($sformatf("rnd%0d", t), p, r, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
